// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared constants, types and age helper for the issue scheduler
//
// Purpose: sizing constants for the RS scan, FU count and ROB indexing, plus
// the modular ROB age function used by every select stage.
// Ports: none (package).

package issue_scheduler_pkg;

   localparam int RS_ENTRIES   = 16;
   localparam int NUM_FU       = 3;
   localparam int ROB_IDX_W    = 6;
   localparam int LAT_W        = 3;
   localparam int LS_PER_CYCLE = 1;
   localparam int RS_IDX_W     = $clog2(RS_ENTRIES);
   // Wide enough to count LS grants across every slot in one cycle.
   localparam int LS_CNT_W     = $clog2(NUM_FU + 1);

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
   typedef logic [RS_IDX_W-1:0]  rs_idx_t;
   typedef logic [LAT_W-1:0]     lat_t;

   // Distance from the ROB head; wraps naturally in ROB_IDX_W bits.
   function automatic rob_idx_t rob_age(input rob_idx_t idx, input rob_idx_t head);
      return idx - head;
   endfunction

endpackage

// File: rtl/issue_age_picker.sv
// rtl/issue_age_picker.sv - combinational oldest-entry selector for one issue slot
//
// Purpose: from an eligible mask and per-entry ages, return the oldest
// entry. LS entries are ignored when ls_allowed is low.
// Ports:
//   eligible   in  RS_ENTRIES           candidate entries
//   is_ls      in  RS_ENTRIES           entry is a load/store address op
//   ages       in  RS_ENTRIES*ROB_IDX_W age per entry, entry e at [e*ROB_IDX_W +: ROB_IDX_W]
//   ls_allowed in  1                    LS entries may still be picked
//   pick_idx   out RS_IDX_W             index of the oldest candidate
//   found      out 1                    a candidate exists

module issue_age_picker
   import issue_scheduler_pkg::*;
(
   input  logic [RS_ENTRIES-1:0]           eligible,
   input  logic [RS_ENTRIES-1:0]           is_ls,
   input  logic [RS_ENTRIES*ROB_IDX_W-1:0] ages,
   input  logic                            ls_allowed,
   output logic [RS_IDX_W-1:0]             pick_idx,
   output logic                            found
);

   logic [ROB_IDX_W-1:0] best_age;

   // Strict less-than keeps the lower index on equal ages.
   always_comb begin
      pick_idx = '0;
      found    = 1'b0;
      best_age = '0;
      for (int e = 0; e < RS_ENTRIES; e++) begin
         if (eligible[e] && (ls_allowed || !is_ls[e])) begin
            if (!found || (ages[e*ROB_IDX_W +: ROB_IDX_W] < best_age)) begin
               found    = 1'b1;
               best_age = ages[e*ROB_IDX_W +: ROB_IDX_W];
               pick_idx = RS_IDX_W'(e);
            end
         end
      end
   end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - oldest-first RS-to-FU issue select with FU occupancy tracking
//
// Purpose: each cycle bind up to NUM_FU ready RS entries to free FUs in
// ascending FU order, oldest ROB age first, limited to LS_PER_CYCLE LS ops.
// Grants are registered; per-FU busy counters and a one-cycle grant mask
// keep FUs and RS entries from being double-issued.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   flush          synchronous squash of grants, busy counters and mask
//   entry_ready    per-entry ready (valid with operands ready)
//   entry_is_ls    per-entry load/store flag
//   entry_rob_idx  per-entry ROB index, packed
//   entry_latency  per-entry FU occupancy cycles, packed
//   rob_head       oldest ROB index
//   fu_ready       per-FU availability
//   issue_valid    per-slot grant pulse (registered)
//   issue_entry    per-slot granted RS entry, packed
//   issue_is_ls    per-slot granted op is load/store
//   fu_busy        per-FU busy counter nonzero

module issue_scheduler
   import issue_scheduler_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic [RS_ENTRIES-1:0]           entry_ready,
   input  logic [RS_ENTRIES-1:0]           entry_is_ls,
   input  logic [RS_ENTRIES*ROB_IDX_W-1:0] entry_rob_idx,
   input  logic [RS_ENTRIES*LAT_W-1:0]     entry_latency,
   input  logic [ROB_IDX_W-1:0]            rob_head,
   input  logic [NUM_FU-1:0]               fu_ready,
   output logic [NUM_FU-1:0]               issue_valid,
   output logic [NUM_FU*RS_IDX_W-1:0]      issue_entry,
   output logic [NUM_FU-1:0]               issue_is_ls,
   output logic [NUM_FU-1:0]               fu_busy
);

   logic [NUM_FU-1:0]               issue_valid_q, issue_valid_d;
   logic [NUM_FU*RS_IDX_W-1:0]      issue_entry_q, issue_entry_d;
   logic [NUM_FU-1:0]               issue_is_ls_q, issue_is_ls_d;
   logic [NUM_FU*LAT_W-1:0]         busy_cnt_q, busy_cnt_d;
   logic [RS_ENTRIES-1:0]           grant_mask_q, grant_mask_d;

   logic [RS_ENTRIES*ROB_IDX_W-1:0] ages;
   logic [RS_ENTRIES-1:0]           elig_base;
   logic [NUM_FU-1:0]               fu_free;
   logic [NUM_FU-1:0]               slot_grant;
   logic [NUM_FU*RS_IDX_W-1:0]      slot_pick;
   logic [NUM_FU*LAT_W-1:0]         slot_lat;
   logic [NUM_FU-1:0]               slot_ls;

   always_comb begin
      ages = '0;
      for (int e = 0; e < RS_ENTRIES; e++) begin
         ages[e*ROB_IDX_W +: ROB_IDX_W] = rob_age(entry_rob_idx[e*ROB_IDX_W +: ROB_IDX_W], rob_head);
      end
   end

   // Entries granted on the last edge are still visible as ready while the
   // RS clears them; hide them for exactly that one cycle.
   assign elig_base = entry_ready & ~grant_mask_q;

   always_comb begin
      fu_free = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         fu_free[f] = fu_ready[f] && (busy_cnt_q[f*LAT_W +: LAT_W] == '0);
      end
   end

   // Select cascade: stage f sees what earlier stages left over. Each stage
   // keeps its own chain signals so no vector feeds back into itself.
   for (genvar f = 0; f < NUM_FU; f++) begin : g_stage
      logic [RS_ENTRIES-1:0] elig_in;
      logic [RS_ENTRIES-1:0] elig_out;
      logic [LS_CNT_W-1:0]   ls_in;
      logic [LS_CNT_W-1:0]   ls_out;
      logic [RS_IDX_W-1:0]   pick;
      logic                  found;
      logic                  grant;
      logic                  ls_allowed;

      if (f == 0) begin : g_head
         assign elig_in = elig_base;
         assign ls_in   = '0;
      end else begin : g_tail
         assign elig_in = g_stage[f-1].elig_out;
         assign ls_in   = g_stage[f-1].ls_out;
      end

      assign ls_allowed = (ls_in < LS_CNT_W'(LS_PER_CYCLE));

      issue_age_picker u_picker (
         .eligible   (elig_in),
         .is_ls      (entry_is_ls),
         .ages       (ages),
         .ls_allowed (ls_allowed),
         .pick_idx   (pick),
         .found      (found)
      );

      assign grant    = fu_free[f] & found & ~flush;
      assign elig_out = grant ? (elig_in & ~(RS_ENTRIES'(1) << pick)) : elig_in;
      assign ls_out   = (grant && entry_is_ls[pick]) ? (ls_in + LS_CNT_W'(1)) : ls_in;

      assign slot_grant[f]                      = grant;
      assign slot_pick[f*RS_IDX_W +: RS_IDX_W]  = pick;
      assign slot_lat[f*LAT_W +: LAT_W]         = entry_latency[pick*LAT_W +: LAT_W];
      assign slot_ls[f]                         = entry_is_ls[pick];
   end

   always_comb begin
      issue_valid_d = slot_grant;
      issue_entry_d = issue_entry_q;
      issue_is_ls_d = issue_is_ls_q;
      busy_cnt_d    = busy_cnt_q;
      grant_mask_d  = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         if (slot_grant[f]) begin
            grant_mask_d[slot_pick[f*RS_IDX_W +: RS_IDX_W]] = 1'b1;
            issue_entry_d[f*RS_IDX_W +: RS_IDX_W]          = slot_pick[f*RS_IDX_W +: RS_IDX_W];
            issue_is_ls_d[f]                               = slot_ls[f];
            // A zero-latency op still occupies its FU for one cycle.
            if (slot_lat[f*LAT_W +: LAT_W] == '0) begin
               busy_cnt_d[f*LAT_W +: LAT_W] = LAT_W'(1);
            end else begin
               busy_cnt_d[f*LAT_W +: LAT_W] = slot_lat[f*LAT_W +: LAT_W];
            end
         end else if (busy_cnt_q[f*LAT_W +: LAT_W] != '0) begin
            busy_cnt_d[f*LAT_W +: LAT_W] = busy_cnt_q[f*LAT_W +: LAT_W] - LAT_W'(1);
         end
      end
      // Grants are already suppressed under flush, which also empties the mask.
      if (flush) begin
         busy_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_valid_q <= '0;
         issue_entry_q <= '0;
         issue_is_ls_q <= '0;
         busy_cnt_q    <= '0;
         grant_mask_q  <= '0;
      end else begin
         issue_valid_q <= issue_valid_d;
         issue_entry_q <= issue_entry_d;
         issue_is_ls_q <= issue_is_ls_d;
         busy_cnt_q    <= busy_cnt_d;
         grant_mask_q  <= grant_mask_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_entry = issue_entry_q;
   assign issue_is_ls = issue_is_ls_q;

   always_comb begin
      fu_busy = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         fu_busy[f] = (busy_cnt_q[f*LAT_W +: LAT_W] != '0);
      end
   end

endmodule
